sort8_loader: RTL and testbench
===============================

SORT8_LOADER -- requirements
Module: sort8_loader

Interface
REQ-001 Parameter PAD, default 8'hFF: fill value for unused slots of a short frame.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream byte valid.
REQ-005 in_ready  output  1  loader accepts a byte this cycle; registered.
REQ-006 in_data  input  8  upstream byte.
REQ-007 in_last  input  1  accepted byte closes the frame early; qualified by in_valid && in_ready.
REQ-008 out_valid  output  1  x0..x7 hold a complete frame for the downstream 8-input sorter.
REQ-009 out_ready  input  1  downstream takes the frame.
REQ-010 x0, x1, x2, x3, x4, x5, x6, x7  output  8 each  frame slots, x0 first-received; registered.
REQ-011 out_count  output  4  real bytes in the frame, 1..8; registered.
REQ-012 frame_cnt  output  16  frames delivered since reset; wraps 16'hFFFF -> 0.

Function
REQ-013 Two states: FILL (collecting) and HOLD (presenting); internal slot index idx, 0..7.
REQ-014 Accept = in_valid && in_ready; no byte is taken in any other cycle.
REQ-015 FILL: in_ready = 1, out_valid = 0; each accept writes in_data to slot idx and increments idx.
REQ-016 Accept with idx == 7, or with in_last = 1: next cycle state = HOLD, out_valid = 1, in_ready = 0, out_count = idx+1.
REQ-017 Early close at index k (in_last, k < 7): slots k+1..7 = PAD in the same edge that sets out_valid.
REQ-018 in_last on the 8th byte behaves as a normal full frame, out_count = 8, no padding.
REQ-019 HOLD: x0..x7 and out_count stay stable until out_valid && out_ready; out_valid never drops without a handshake.
REQ-020 Handshake in HOLD: next cycle state = FILL, idx = 0, out_valid = 0, in_ready = 1, frame_cnt += 1; slot registers keep stale values until overwritten.
REQ-021 Latency: last accepted byte -> out_valid high on the next edge (1 cycle); handshake -> in_ready high on the next edge (1 cycle).
REQ-022 Minimum frame period for 8 bytes with out_ready tied high: 9 cycles (8 accept + 1 hold).
REQ-023 No combinational path from out_ready or in_valid to in_ready or out_valid.
REQ-024 out_ready asserted while out_valid = 0 is ignored; in_valid while in_ready = 0 is ignored and in_data is not sampled.
REQ-025 in_last with in_valid = 0 or in_ready = 0 has no effect.

Reset
REQ-026 rst_n low, asynchronously: state = FILL, idx = 0, in_ready = 0, out_valid = 0, x0..x7 = 8'h00, out_count = 0, frame_cnt = 0.
REQ-027 First rising edge after rst_n release: in_ready = 1; no byte is accepted on that edge.
REQ-028 Reset mid-frame or during HOLD discards the partial or held frame; frame_cnt is not incremented.

Verification
REQ-029 Full frame: bytes 8'h10..8'h17 with in_valid held high and out_ready = 1 -> x0..x7 = 10..17, out_count = 8, out_valid high exactly 1 cycle, frame_cnt = 1.
REQ-030 Short frame: 8'h05, 8'h03, 8'h09 with in_last on 8'h09 -> x0..x2 = 05,03,09, x3..x7 = FF, out_count = 3.
REQ-031 Backpressure: out_ready = 0 for 5 cycles after out_valid -> in_ready = 0 and x0..x7 stable for all 5 cycles; handshake on cycle 6; in_ready = 1 on the next cycle.
REQ-032 Bubbles: in_valid toggled every other cycle over 8 bytes -> exactly 8 accepts, frame correct, out_valid one cycle after the 8th accept.
REQ-033 Reset mid-frame after 4 bytes, then 8 new bytes 8'hA0..8'hA7 -> frame is A0..A7, out_count = 8, frame_cnt = 1.
REQ-034 Wrap: frame_cnt preloaded by running 65536 one-byte frames -> frame_cnt = 0.

Source files
------------

// File: rtl/sort8_loader_if.sv
// Byte-in / frame-out bundle between an upstream byte source, the sort8 loader
// and the downstream 8-input sorter.
interface sort8_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  x0, x1, x2, x3, x4, x5, x6, x7;
  logic [3:0]  out_count;
  logic [15:0] frame_cnt;

  // slave: the loader itself; master: the surrounding environment.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, x0, x1, x2, x3, x4, x5, x6, x7, out_count, frame_cnt
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, x0, x1, x2, x3, x4, x5, x6, x7, out_count, frame_cnt
  );
endinterface

// File: rtl/sort8_loader.sv
// Collects up to eight bytes into a frame for an 8-input sorter, padding short
// frames, and holds the frame until the sorter takes it.
module sort8_loader #(
  parameter logic [7:0] PAD = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  sort8_loader_if.slave     bus,
  output logic [0:0]        dbg_state
);

  // Handshakes: a byte moves when in_valid && in_ready at a rising edge, a frame
  // moves when out_valid && out_ready; in_ready/out_valid are pure registers.
  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]  state_q;
  logic [2:0]  idx_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [7:0]  slot_q [8];
  logic [3:0]  count_q;
  logic [15:0] frame_cnt_q;

  logic accept;
  logic close;

  assign accept = bus.in_valid && in_ready_q;
  assign close  = accept && (bus.in_last || (idx_q == 3'd7));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      idx_q       <= 3'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      count_q     <= 4'd0;
      frame_cnt_q <= 16'd0;
      for (int i = 0; i < 8; i++) slot_q[i] <= 8'h00;
    end else begin
      case (state_q)
        S_FILL: begin
          // Also raises in_ready on the first edge after reset release.
          in_ready_q <= !close;
          if (accept) begin
            for (int i = 0; i < 8; i++) begin
              if (3'(i) == idx_q) slot_q[i] <= bus.in_data;
              else if (close && (3'(i) > idx_q)) slot_q[i] <= PAD;
            end
            if (close) begin
              state_q     <= S_HOLD;
              out_valid_q <= 1'b1;
              count_q     <= {1'b0, idx_q} + 4'd1;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            state_q     <= S_FILL;
            idx_q       <= 3'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_count = count_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.x0 = slot_q[0];
  assign bus.x1 = slot_q[1];
  assign bus.x2 = slot_q[2];
  assign bus.x3 = slot_q[3];
  assign bus.x4 = slot_q[4];
  assign bus.x5 = slot_q[5];
  assign bus.x6 = slot_q[6];
  assign bus.x7 = slot_q[7];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sort8_loader.sv
// Bench for sort8_loader: directed and random frames checked against a
// frame-level reference model through an expected-frame queue.
module tb_sort8_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sort8_loader_if bus ();
  logic [0:0] dbg_state;

  sort8_loader #(.PAD(8'hFF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  logic [67:0] exp_q[$];
  logic [15:0] exp_frames = 16'd0;
  bit   bp_hold = 1'b0;
  int   rdy_pct = 100;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {count, slot7..slot0}, unused slots padded with FF.
  function automatic logic [67:0] model(input logic [7:0] b[8], input int n);
    logic [67:0] r;
    r[67:64] = 4'(n);
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = (i < n) ? b[i] : 8'hFF;
    return r;
  endfunction

  function automatic logic [67:0] cur_frame();
    return {bus.out_count, bus.x7, bus.x6, bus.x5, bus.x4, bus.x3, bus.x2, bus.x1, bus.x0};
  endfunction

  // ---------------- downstream ready driver ----------------
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = !bp_hold && ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        hold_prev = 1'b0;
  logic [67:0] prev_frame;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_stable", cur_frame(), prev_frame);
        check("hold_valid", 68'(bus.out_valid), 68'd1);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %h expected none", cur_frame());
        end else begin
          check("frame", cur_frame(), exp_q.pop_front());
        end
        hold_prev = 1'b0;
      end else if (bus.out_valid) begin
        hold_prev  = 1'b1;
        prev_frame = cur_frame();
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_frame(input logic [7:0] b[8], input int n, input bit last_on_n,
                            input bit bubbles, input bit push);
    int waited;
    if (push) begin
      exp_q.push_back(model(b, n));
      exp_frames = exp_frames + 16'd1;
    end
    for (int i = 0; i < n; i++) begin
      if (bubbles && i > 0) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.in_last  = 1'b1;
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b[i];
      bus.in_last  = last_on_n && (i == n - 1);
      waited = 0;
      while (!bus.in_ready) begin
        @(negedge clk);
        waited++;
        if (waited > 500) begin
          checks++;
          errors++;
          $display("FAIL in_ready_timeout: got 0 expected 1");
          bus.in_valid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (push) begin
      check("close_out_valid", 68'(bus.out_valid), 68'd1);
      check("close_in_ready", 68'(bus.in_ready), 68'd0);
    end
  endtask

  task automatic drain_and_count(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    check(name, 68'(bus.frame_cnt), 68'(exp_frames));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_frames = 16'd0;
    #1;
    check("rst_handshake", {66'd0, bus.in_ready, bus.out_valid}, 68'd0);
    check("rst_slots", cur_frame(), 68'd0);
    check("rst_frame_cnt", 68'(bus.frame_cnt), 68'd0);
    check("rst_state", 68'(dbg_state), 68'd0);
    // A byte presented across release must not be taken on the first edge.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    bus.in_last  = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("first_edge_in_ready", 68'(bus.in_ready), 68'd1);
    check("first_edge_no_accept", 68'(bus.out_valid), 68'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] b[8];
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Full frame 10..17, out_valid high for exactly one cycle.
    for (int i = 0; i < 8; i++) b[i] = 8'h10 + 8'(i);
    send_frame(b, 8, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("full_one_cycle", 68'(bus.out_valid), 68'd0);
    drain_and_count("full_frame_cnt");

    // Short frame 05,03,09 closed by in_last.
    b[0] = 8'h05; b[1] = 8'h03; b[2] = 8'h09;
    send_frame(b, 3, 1'b1, 1'b0, 1'b1);
    drain_and_count("short_frame_cnt");

    // in_last on the eighth byte is a normal full frame.
    for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    send_frame(b, 8, 1'b1, 1'b0, 1'b1);
    drain_and_count("last8_frame_cnt");

    // Backpressure for five cycles, then handshake.
    bp_hold = 1'b1;
    for (int i = 0; i < 8; i++) b[i] = 8'h40 + 8'(i);
    send_frame(b, 8, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("bp_in_ready", 68'(bus.in_ready), 68'd0);
      check("bp_state", 68'(dbg_state), 68'd1);
      if (k < 4) @(negedge clk);
    end
    bp_hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", 68'(bus.in_ready), 68'd1);
    check("bp_release_out_valid", 68'(bus.out_valid), 68'd0);
    drain_and_count("bp_frame_cnt");

    // Bubbles between every byte.
    for (int i = 0; i < 8; i++) b[i] = 8'h80 + 8'(i);
    send_frame(b, 8, 1'b0, 1'b1, 1'b1);
    drain_and_count("bubble_frame_cnt");

    // Reset after four bytes, then a fresh frame.
    for (int i = 0; i < 8; i++) b[i] = 8'h30 + 8'(i);
    send_frame(b, 4, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 8; i++) b[i] = 8'hA0 + 8'(i);
    send_frame(b, 8, 1'b0, 1'b0, 1'b1);
    drain_and_count("after_reset_frame_cnt");

    // Random frames with random backpressure and bubbles.
    rdy_pct = 60;
    for (int f = 0; f < 150; f++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
      send_frame(b, n, (n < 8) ? 1'b1 : 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b1);
    end
    drain_and_count("random_frame_cnt");

    // Counter wrap: preload near the top rather than running 65536 frames.
    rdy_pct = 100;
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFD;
    #1;
    release dut.frame_cnt_q;
    exp_frames = 16'hFFFD;
    for (int f = 0; f < 3; f++) begin
      b[0] = 8'(f);
      send_frame(b, 1, 1'b1, 1'b0, 1'b1);
    end
    drain_and_count("wrap_frame_cnt");
    check("wrap_is_zero", 68'(bus.frame_cnt), 68'd0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
